// File: rtl/bicubic_pkg.sv
// ---------------------------------------------------------------------------
// bicubic_pkg
// Shared constants and types for the bicubic interpolation datapath. The
// stage-1 and stage-2 multipliers and both accumulators import this package.
//   FRAC_BITS            fixed-point fraction bits of the weights
//                        (the four weights of a phase sum to 2^FRAC_BITS)
//   TAPS                 products summed per output sample
//   INTER_PRODUCT_WIDTH  width of a signed stage-1 product
//   ACC_WIDTH            accumulator width, INTER_PRODUCT_WIDTH + clog2(TAPS)
//   PIXEL_MAX            largest legal output pixel value
//   weight_code_e        3-bit code selecting one of the signed weights
//   weight_value()       maps a weight code to its signed weight
// ---------------------------------------------------------------------------
package bicubic_pkg;

   localparam int FRAC_BITS           = 11;
   localparam int TAPS                = 4;
   localparam int INTER_PRODUCT_WIDTH = 24;
   localparam int ACC_WIDTH           = 26;
   localparam int PIXEL_MAX           = 255;
   localparam int WEIGHT_WIDTH        = 12;

   // The eight distinct signed weights used by all interpolation phases
   typedef enum logic [2:0] {
      W_N21   = 3'd0,
      W_N135  = 3'd1,
      W_N147  = 3'd2,
      W_N225  = 3'd3,
      W_P235  = 3'd4,
      W_P873  = 3'd5,
      W_P1535 = 3'd6,
      W_P1981 = 3'd7
   } weight_code_e;

   // Decodes a weight code into the signed weight applied by the multipliers
   function automatic logic signed [WEIGHT_WIDTH-1:0] weight_value(input weight_code_e code);
      logic signed [WEIGHT_WIDTH-1:0] w;
      case (code)
         W_N21:   w = -12'sd21;
         W_N135:  w = -12'sd135;
         W_N147:  w = -12'sd147;
         W_N225:  w = -12'sd225;
         W_P235:  w = 12'sd235;
         W_P873:  w = 12'sd873;
         W_P1535: w = 12'sd1535;
         default: w = 12'sd1981;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/bicubic_round_clamp.sv
// ---------------------------------------------------------------------------
// bicubic_round_clamp
// Combinational rounding, rescaling and clamping of an accumulated sum of
// weighted pixels back into the 0..PIXEL_MAX pixel range.
//   sum   input  ACC_WIDTH  signed accumulated sum, weights scaled by 2^FRAC_BITS
//   data  output 9          signed pixel (MSB always 0), range 0..PIXEL_MAX
//   sat   output 1          the rounded value lay outside 0..PIXEL_MAX
// ---------------------------------------------------------------------------
module bicubic_round_clamp
   import bicubic_pkg::*;
#(
   parameter int ACC_WIDTH = bicubic_pkg::ACC_WIDTH,
   parameter int FRAC_BITS = bicubic_pkg::FRAC_BITS
) (
   input  logic signed [ACC_WIDTH-1:0] sum,
   output logic        [8:0]           data,
   output logic                        sat
);

   localparam logic signed [ACC_WIDTH-1:0] HALF    = ACC_WIDTH'(2 ** (FRAC_BITS - 1));
   localparam logic signed [ACC_WIDTH-1:0] MAX_VAL = ACC_WIDTH'(PIXEL_MAX);

   logic signed [ACC_WIDTH-1:0] biased;
   logic signed [ACC_WIDTH-1:0] rounded;

   // Adding half an LSB before the arithmetic shift rounds half up toward
   // +inf. The add stays at ACC_WIDTH; the accumulator width leaves headroom
   // for it, so no wrap occurs for legal products.
   always_comb begin
      biased  = sum + HALF;
      rounded = biased >>> FRAC_BITS;
      data    = 9'd0;
      sat     = 1'b0;
      if (rounded[ACC_WIDTH-1]) begin
         data = 9'd0;
         sat  = 1'b1;
      end else if (rounded > MAX_VAL) begin
         data = 9'(PIXEL_MAX);
         sat  = 1'b1;
      end else begin
         data = rounded[8:0];
         sat  = 1'b0;
      end
   end

endmodule

// File: rtl/bicubic_accum_stage1.sv
// ---------------------------------------------------------------------------
// bicubic_accum_stage1
// Consumer end of the stage-1 bicubic multiplier. Sums TAPS signed products
// per output sample, then rounds, rescales and clamps the group to a pixel
// that is offered downstream with a valid/ready handshake.
//   clk        input  1                    clock, rising edge
//   rst        input  1                    asynchronous active-high reset
//   clr        input  1                    synchronous abort of the partial group
//   s_valid    input  1                    product valid
//   s_ready    output 1                    product accepted when s_valid && s_ready
//   s_product  input  INTER_PRODUCT_WIDTH  signed product
//   m_valid    output 1                    result valid
//   m_ready    input  1                    downstream accept
//   m_data     output 9                    result pixel, 0..255 (MSB always 0)
//   m_sat      output 1                    result was clamped, qualified by m_valid
// ---------------------------------------------------------------------------
module bicubic_accum_stage1
   import bicubic_pkg::*;
#(
   parameter int INTER_PRODUCT_WIDTH = bicubic_pkg::INTER_PRODUCT_WIDTH,
   parameter int TAPS                = bicubic_pkg::TAPS,
   parameter int FRAC_BITS           = bicubic_pkg::FRAC_BITS,
   parameter int ACC_WIDTH           = bicubic_pkg::ACC_WIDTH
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  clr,
   input  logic                                  s_valid,
   output logic                                  s_ready,
   input  logic signed [INTER_PRODUCT_WIDTH-1:0] s_product,
   output logic                                  m_valid,
   input  logic                                  m_ready,
   output logic        [8:0]                     m_data,
   output logic                                  m_sat
);

   localparam int              CNT_WIDTH = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [CNT_WIDTH-1:0] LAST_TAP = CNT_WIDTH'(TAPS - 1);

   logic        [CNT_WIDTH-1:0] tap_cnt;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] product_ext;
   logic signed [ACC_WIDTH-1:0] sum_next;
   logic                        is_last;
   logic                        accept;
   logic        [8:0]           rc_data;
   logic                        rc_sat;

   // Only the closing tap can be stalled: it is the one that writes the
   // output register, so it waits until that register is free or being
   // drained this cycle. The m_ready path is combinational by design.
   always_comb begin
      is_last     = (tap_cnt == LAST_TAP);
      s_ready     = !clr && (!is_last || !m_valid || m_ready);
      accept      = s_valid && s_ready;
      product_ext = {{(ACC_WIDTH - INTER_PRODUCT_WIDTH){s_product[INTER_PRODUCT_WIDTH-1]}}, s_product};
      sum_next    = acc + product_ext;
   end

   bicubic_round_clamp #(
      .ACC_WIDTH (ACC_WIDTH),
      .FRAC_BITS (FRAC_BITS)
   ) u_round_clamp (
      .sum  (sum_next),
      .data (rc_data),
      .sat  (rc_sat)
   );

   // Tap counter and running sum. clr wins over an incoming beat (s_ready is
   // already low then); the closing beat restarts the group for the next
   // sample on the same edge its result is captured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tap_cnt <= '0;
         acc     <= '0;
      end else if (clr) begin
         tap_cnt <= '0;
         acc     <= '0;
      end else if (accept) begin
         if (is_last) begin
            tap_cnt <= '0;
            acc     <= '0;
         end else begin
            tap_cnt <= tap_cnt + CNT_WIDTH'(1);
            acc     <= sum_next;
         end
      end
   end

   // Output register. A new result may replace one being drained in the same
   // cycle, giving back-to-back results without a bubble; otherwise the held
   // result stays stable until the downstream accepts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_sat   <= 1'b0;
      end else if (accept && is_last) begin
         m_valid <= 1'b1;
         m_data  <= rc_data;
         m_sat   <= rc_sat;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bicubic_accum_stage1.sv
// ---------------------------------------------------------------------------
// tb_bicubic_accum_stage1
// Directed, self-checking bench for bicubic_accum_stage1. Inputs change 1 ns
// after the rising edge; outputs are sampled there, away from the edge.
// ---------------------------------------------------------------------------
module tb_bicubic_accum_stage1;

   logic               clk;
   logic               rst;
   logic               clr;
   logic               s_valid;
   logic               s_ready;
   logic signed [23:0] s_product;
   logic               m_valid;
   logic               m_ready;
   logic        [8:0]  m_data;
   logic               m_sat;

   int compare_count;
   int fail_count;

   bicubic_accum_stage1 dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_product (s_product),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_sat     (m_sat)
   );

   // 100 MHz free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 ns past the next rising edge
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Drive the upstream side and let combinational outputs settle
   task automatic applyStimulus(input logic v, input logic signed [23:0] p, input logic c);
      s_valid   = v;
      s_product = p;
      clr       = c;
      #1;
   endtask

   // One product presented for exactly one clock edge
   task automatic send_beat(input logic signed [23:0] p);
      applyStimulus(1'b1, p, 1'b0);
      next_cycle();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compare_count++;
      assert (observed === expected) else begin
         fail_count++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   task automatic check_result(input string tag, input logic v, input logic [8:0] d, input logic s);
      checkOutput({tag, "_valid"}, 32'(m_valid), 32'(v));
      checkOutput({tag, "_data"},  32'(m_data),  32'(d));
      checkOutput({tag, "_sat"},   32'(m_sat),   32'(s));
   endtask

   initial begin
      compare_count = 0;
      fail_count    = 0;
      rst           = 1'b1;
      clr           = 1'b0;
      s_valid       = 1'b0;
      s_product     = '0;
      m_ready       = 1'b1;

      // Reset state
      next_cycle();
      next_cycle();
      check_result("reset", 1'b0, 9'd0, 1'b0);
      rst = 1'b0;
      #1;
      checkOutput("reset_s_ready", 32'(s_ready), 32'd1);

      // Nominal group: pixel 100 times weights -21, 235, 1981, -147
      send_beat(-24'sd2100);
      send_beat(24'sd23500);
      send_beat(24'sd198100);
      checkOutput("nom_no_early_valid", 32'(m_valid), 32'd0);
      send_beat(-24'sd14700);
      applyStimulus(1'b0, 24'sd0, 1'b0);
      check_result("nominal", 1'b1, 9'd100, 1'b0);
      next_cycle();
      checkOutput("nom_single_pulse", 32'(m_valid), 32'd0);

      // High clamp: r = 276
      send_beat(24'sd0);
      send_beat(24'sd59925);
      send_beat(24'sd505155);
      send_beat(24'sd0);
      applyStimulus(1'b0, 24'sd0, 1'b0);
      check_result("high_clamp", 1'b1, 9'd255, 1'b1);

      // Low clamp: r = -21
      send_beat(-24'sd5355);
      send_beat(24'sd0);
      send_beat(24'sd0);
      send_beat(-24'sd37485);
      applyStimulus(1'b0, 24'sd0, 1'b0);
      check_result("low_clamp", 1'b1, 9'd0, 1'b1);

      // Rounding boundary: exactly half an LSB rounds up
      send_beat(24'sd1024);
      send_beat(24'sd0);
      send_beat(24'sd0);
      send_beat(24'sd0);
      applyStimulus(1'b0, 24'sd0, 1'b0);
      check_result("round_1024", 1'b1, 9'd1, 1'b0);

      // Just under half an LSB rounds down
      send_beat(24'sd1023);
      send_beat(24'sd0);
      send_beat(24'sd0);
      send_beat(24'sd0);
      applyStimulus(1'b0, 24'sd0, 1'b0);
      check_result("round_1023", 1'b1, 9'd0, 1'b0);
      next_cycle();

      // Back-pressure: park a result of 100, then stream a group worth 50
      m_ready = 1'b0;
      send_beat(24'sd0);
      send_beat(24'sd0);
      send_beat(24'sd0);
      send_beat(24'sd204800);
      applyStimulus(1'b0, 24'sd0, 1'b0);
      check_result("bp_first", 1'b1, 9'd100, 1'b0);
      applyStimulus(1'b1, 24'sd102400, 1'b0);
      checkOutput("bp_tap0_ready", 32'(s_ready), 32'd1);
      next_cycle();
      send_beat(24'sd0);
      applyStimulus(1'b1, 24'sd0, 1'b0);
      checkOutput("bp_tap2_ready", 32'(s_ready), 32'd1);
      next_cycle();
      applyStimulus(1'b1, 24'sd0, 1'b0);
      checkOutput("bp_last_stalled", 32'(s_ready), 32'd0);
      next_cycle();
      check_result("bp_hold", 1'b1, 9'd100, 1'b0);
      m_ready = 1'b1;
      #1;
      checkOutput("bp_last_released", 32'(s_ready), 32'd1);
      next_cycle();
      applyStimulus(1'b0, 24'sd0, 1'b0);
      check_result("bp_back_to_back", 1'b1, 9'd50, 1'b0);
      next_cycle();
      checkOutput("bp_drained", 32'(m_valid), 32'd0);

      // clr mid-group discards the partial sum and refuses the concurrent beat
      send_beat(24'sd5000);
      send_beat(24'sd7000);
      applyStimulus(1'b1, 24'sd99999, 1'b1);
      checkOutput("clr_s_ready", 32'(s_ready), 32'd0);
      next_cycle();
      checkOutput("clr_no_result", 32'(m_valid), 32'd0);
      send_beat(-24'sd2100);
      send_beat(24'sd23500);
      send_beat(24'sd198100);
      send_beat(-24'sd14700);
      applyStimulus(1'b0, 24'sd0, 1'b0);
      check_result("after_clr", 1'b1, 9'd100, 1'b0);
      next_cycle();

      // Async reset with a saturated result pending and 3 beats accumulated
      m_ready = 1'b0;
      send_beat(24'sd0);
      send_beat(24'sd59925);
      send_beat(24'sd505155);
      send_beat(24'sd0);
      send_beat(24'sd0);
      send_beat(24'sd59925);
      send_beat(24'sd505155);
      applyStimulus(1'b0, 24'sd0, 1'b0);
      check_result("pre_reset", 1'b1, 9'd255, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      check_result("async_reset", 1'b0, 9'd0, 1'b0);
      #1;
      rst     = 1'b0;
      m_ready = 1'b1;
      next_cycle();
      send_beat(-24'sd2100);
      send_beat(24'sd23500);
      send_beat(24'sd198100);
      checkOutput("post_reset_no_early", 32'(m_valid), 32'd0);
      send_beat(-24'sd14700);
      applyStimulus(1'b0, 24'sd0, 1'b0);
      check_result("post_reset", 1'b1, 9'd100, 1'b0);
      next_cycle();
      checkOutput("post_reset_single", 32'(m_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
      $finish;
   end

endmodule

// File: doc/bicubic_accum_stage1.md
Name: bicubic_accum_stage1

Overview:
- Consumer end of the stage-1 bicubic multiplier: accepts the signed weighted-pixel products, one per handshake, and accumulates TAPS of them per output sample.
- Each completed group is rounded, rescaled by 2^FRAC_BITS (weights sum to 2048), clamped to 0..255, and presented with a valid/ready handshake.
- The result is a 9-bit signed pixel that stage 2 consumes directly.
- Sits between the stage-1 multiplier array (products aligned with a valid delay line) and the stage-2 multiplier.

Parameters:
- INTER_PRODUCT_WIDTH, 24, width of each signed input product.
- TAPS, 4, products summed per output sample.
- FRAC_BITS, 11, fixed-point fraction bits of the weights (sum of weights = 2^FRAC_BITS).
- ACC_WIDTH, 26, accumulator width; must be at least INTER_PRODUCT_WIDTH + clog2(TAPS).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous abort of the partial group in progress.
- s_valid  input  1  product valid.
- s_ready  output  1  product accepted when s_valid && s_ready.
- s_product  input  INTER_PRODUCT_WIDTH  signed product.
- m_valid  output  1  result valid.
- m_ready  input  1  downstream accept.
- m_data  output  9  signed result; MSB always 0, value range 0..255.
- m_sat  output  1  result was clamped; qualified by m_valid.

Behaviour:
- Reset (async, rst=1): tap_cnt=0, acc=0, m_valid=0, m_data=0, m_sat=0, s_ready=1 after release.
- Reset mid-group discards the partial sum. No output is produced for that group.
- Accept: a beat is accepted when s_valid && s_ready && !clr.
  - A non-last beat (tap_cnt < TAPS-1) does acc += sext(s_product) and tap_cnt++.
- Last beat (tap_cnt == TAPS-1):
  - sum = acc + sext(s_product), computed at full ACC_WIDTH.
  - r = (sum + 2^(FRAC_BITS-1)) >>> FRAC_BITS, arithmetic shift (round half up toward +inf).
  - If r < 0: m_data=0, m_sat=1.
  - If r > 255: m_data=255, m_sat=1.
  - Otherwise: m_data=r, m_sat=0.
  - m_valid=1 on the next edge, i.e. one cycle of latency from last-beat acceptance.
  - acc=0 and tap_cnt=0 on the same edge.
- Output hold: m_data and m_sat are held stable while m_valid && !m_ready.
  - m_valid drops on the edge where m_ready=1, unless a new last beat is accepted that same cycle. In that case m_valid stays 1 and m_data updates (back-to-back results, no bubble).
- s_ready = !clr && ((tap_cnt != TAPS-1) || !m_valid || m_ready).
  - Only the last tap is back-pressured; taps 0..TAPS-2 are always accepted.
  - s_ready has a combinational path from m_ready; no combinational path from s_valid.
- clr: sets tap_cnt=0 and acc=0. s_ready is forced 0 that cycle, so a concurrent product is not accepted. The output register and m_valid are unaffected.
- Overflow: ACC_WIDTH guarantees no wrap for TAPS full-scale products. The rounding add is also done at ACC_WIDTH.
- No X propagation: all state is reset. s_product is ignored when s_valid=0.

Decomposition:
- Shared package bicubic_pkg:
  - FRAC_BITS, TAPS, INTER_PRODUCT_WIDTH, PIXEL_MAX=255.
  - The signed weight constants (-21, -135, -147, -225, 235, 873, 1535, 1981) and the 3-bit weight code enumeration also used by the stage-1 and stage-2 multipliers.
- One natural sub-module: bicubic_round_clamp. It is combinational and maps an ACC_WIDTH sum to 9-bit m_data plus sat, using the round/shift/clamp rule above. It is reused by the stage-2 accumulator.
- The top block holds the counter, accumulator, handshake and output register.

Test Plan:
- Nominal, m_ready=1: products -2100, 23500, 198100, -14700 (pixel 100 × weights -21, 235, 1981, -147) on consecutive cycles -> m_valid for exactly 1 cycle, 1 cycle after the 4th beat, m_data=100, m_sat=0.
- High clamp: products 0, 59925, 505155, 0 -> sum 565080, r=276 -> m_data=255, m_sat=1.
- Low clamp and rounding:
  - -5355, 0, 0, -37485 -> r=-21 -> m_data=0, m_sat=1.
  - Separate group summing to 1024 -> m_data=1.
  - Group summing to 1023 -> m_data=0.
- Back-pressure:
  - Hold m_ready=0 with a result pending and stream the next group -> 3 beats accepted, s_ready=0 at the 4th, m_data stable.
  - Raise m_ready -> 4th beat accepted that same cycle, m_valid stays 1, m_data updates to the new result.
- clr mid-group: 2 beats, then clr=1 with s_valid=1 -> that beat is not accepted (s_ready=0). The next 4 beats (-2100, 23500, 198100, -14700) yield m_data=100, proving the accumulator was cleared.
- Async reset: assert rst between clock edges while 3 beats are accumulated and a result is pending -> m_valid=0, m_data=0 and m_sat=0 immediately. After release, a fresh 4-beat group produces the correct single result.
